bp_fe_queue_fifo: RTL and testbench
===================================

# bp_fe_queue_fifo

Elastic buffer between the frontend PC generator and the backend issue stage, carrying packed FE queue messages (fetched instructions and FE exceptions). It accepts one message per cycle from the PC generator using a ready/valid handshake. It presents the oldest message to the backend using a valid/yumi handshake. A backend flush (any non-attaboy FE command) discards all buffered speculative messages in one cycle, and a saturating counter records how many messages were discarded for performance monitoring.

## Interface
- fe_queue_width_p, default 128: width of one FE queue message in bits.
- els_p, default 8: number of entries; power of two, ≥ 2.
- ptr_width_lp (local) = log2(els_p).
- count_width_lp (local) = log2(els_p+1).
- clk_i  input  1  single clock; all state changes on its rising edge.
- reset_i  input  1  reset; asynchronous, active-low (0 = reset asserted).
- data_i  input  fe_queue_width_p  message from the PC generator.
- v_i  input  1  data_i valid.
- ready_o  output  1  buffer can accept a message this cycle.
- data_o  output  fe_queue_width_p  oldest buffered message.
- v_o  output  1  data_o valid (buffer non-empty).
- yumi_i  input  1  backend consumes data_o this cycle; legal only when v_o=1.
- clr_i  input  1  flush: discard all contents this cycle.
- count_o  output  count_width_lp  current occupancy, 0..els_p.
- drop_count_o  output  16  saturating total of messages discarded by clr_i.

## Operation
- Storage: els_p × fe_queue_width_p register array.
- Pointers: rd_ptr and wr_ptr, ptr_width_lp bits each, wrap modulo els_p.
- Occupancy: count register, count_width_lp bits.
- enq = v_i & ready_o: writes data_i at wr_ptr, then wr_ptr+1.
- v_i while ready_o=0 is ignored; the data is not stored and no error is flagged.
- deq = yumi_i & v_o: advances rd_ptr+1.
- count_next = count + enq − deq.
- Simultaneous enq and deq leaves count unchanged and moves both pointers.
- ready_o = (count != els_p); it is a registered-state decode with no dependence on yumi_i.
  - At full, an enq is not accepted even if yumi_i=1 in the same cycle.
- v_o = (count != 0). data_o = mem[rd_ptr]. There is no input-to-output bypass.
- clr_i has priority over everything. On a cycle with clr_i=1:
  - rd_ptr, wr_ptr and count go to 0.
  - Any enq and deq in that cycle are discarded.
  - drop_count increases by the pre-clear count, saturating at 16'hFFFF.
- drop_count_o is never reset by clr_i; only reset_i clears it.
- Storage array contents are not reset; data_o is don't-care while v_o=0.
- yumi_i with v_o=0 is illegal; the design must not change state for it, and the bench flags it.

## Timing
- Reset (reset_i=0, asynchronous) forces:
  - rd_ptr=0, wr_ptr=0, count=0, drop_count=0.
  - Outputs: v_o=0, ready_o=1, count_o=0, drop_count_o=0.
- Reset deassertion is synchronized externally. The first enq can occur in the first cycle after release.
- Enqueue-to-visible latency is 1 cycle: a message enqueued at edge N drives v_o/data_o after edge N.
- Dequeue takes effect at the edge: the next entry appears at data_o after that edge.
- With continuous v_i and yumi_i, throughput is 1 message/cycle at any occupancy below full.
- Clear takes effect at the edge:
  - The cycle after clr_i shows v_o=0, ready_o=1, count_o=0.
  - drop_count_o is updated in that same next cycle.
- Reset asserted mid-operation aborts any in-flight handshake. No message survives.

## Test plan
- Fill/drain, els_p=8:
  - Enqueue 8 messages with values 0x1..0x8 and no yumi. Required: ready_o=0 after the 8th, count_o=8.
  - A 9th v_i is ignored.
  - Then dequeue all 8. Required: data_o is 0x1..0x8 in order, v_o=0 and ready_o=1 after the last.
- Wrap-around: run a 40-cycle stream with v_i and yumi_i both asserted every cycle, starting from count 3. Required: count_o stays 3 and output order matches input order across pointer wrap.
- Full with simultaneous yumi: at count=8, assert v_i=1 and yumi_i=1. Required: the input is not accepted, count_o=7 next cycle, and the dropped message never appears at data_o.
- Flush: at count=5, assert clr_i together with v_i=1 and yumi_i=1. Required: next cycle count_o=0, v_o=0 and drop_count_o=5. The next enqueued message is the next data_o.
- Saturation: preload drop_count to 0xFFFE, then clear with count=4. Required: drop_count_o=0xFFFF. A further clear keeps it at 0xFFFF.
- Async reset: assert reset_i=0 mid-cycle at count=6. Required: outputs reach reset values immediately, without waiting for a clock edge. After release, v_o=0, ready_o=1 and drop_count_o=0.

Source files
------------

// File: rtl/bp_fe_queue_fifo.sv
// Elastic FE queue between the PC generator and the backend issue stage.
// Ready/valid in, valid/yumi out, single-cycle flush with a saturating drop counter.
module bp_fe_queue_fifo #(
   parameter int unsigned fe_queue_width_p = 128,
   parameter int unsigned els_p            = 8,
   localparam int unsigned ptr_width_lp    = $clog2(els_p),
   localparam int unsigned count_width_lp  = $clog2(els_p + 1)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [fe_queue_width_p-1:0] data_i,
   input  logic                        v_i,
   output logic                        ready_o,
   output logic [fe_queue_width_p-1:0] data_o,
   output logic                        v_o,
   input  logic                        yumi_i,
   input  logic                        clr_i,
   output logic [count_width_lp-1:0]   count_o,
   output logic [15:0]                 drop_count_o
);

   logic [fe_queue_width_p-1:0] mem_q [els_p];
   logic [ptr_width_lp-1:0]     rd_ptr_q, rd_ptr_d;
   logic [ptr_width_lp-1:0]     wr_ptr_q, wr_ptr_d;
   logic [count_width_lp-1:0]   count_q, count_d;
   logic [15:0]                 drop_count_q, drop_count_d;
   logic                        enq, deq, mem_we;
   logic [16:0]                 drop_sum;

   assign ready_o      = (count_q != count_width_lp'(els_p));
   assign v_o          = (count_q != '0);
   assign data_o       = mem_q[rd_ptr_q];
   assign count_o      = count_q;
   assign drop_count_o = drop_count_q;

   assign enq    = v_i & ready_o;
   assign deq    = yumi_i & v_o;
   assign mem_we = enq & ~clr_i;

   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      drop_count_d = drop_count_q;
      drop_sum     = {1'b0, drop_count_q} + 17'(count_q);
      if (clr_i) begin
         // Flush wins over any handshake in the same cycle.
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         count_d      = '0;
         drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
         if (deq) rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
         count_d = count_q + count_width_lp'(enq) - count_width_lp'(deq);
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         drop_count_q <= '0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Payload storage is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: tb/tb_bp_fe_queue_fifo.sv
// Scoreboard bench for bp_fe_queue_fifo: queue-based model, randomized and directed traffic.
module tb_bp_fe_queue_fifo;
   localparam int unsigned W = 128;
   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] data_i, data_o;
   logic         v_i, ready_o, v_o, yumi_i, clr_i;
   logic [3:0]   count_o;
   logic [15:0]  drop_count_o;

   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] sb [$];
   int unsigned  model_drop = 0;

   bp_fe_queue_fifo #(.fe_queue_width_p(W), .els_p(N)) dut (
      .clk_i(clk), .reset_i(reset_n), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
      .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .clr_i(clr_i), .count_o(count_o),
      .drop_count_o(drop_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Check visible state against the model, then drive one cycle of stimulus.
   task automatic step(input logic v, input logic y, input logic c, input logic [W-1:0] d);
      int unsigned sum;
      @(negedge clk);
      chk("count_o", W'(count_o), W'(sb.size()));
      chk("v_o", W'(v_o), W'(sb.size() != 0));
      chk("ready_o", W'(ready_o), W'(sb.size() != N));
      chk("drop_count_o", W'(drop_count_o), W'(model_drop));
      v_i    = v;
      yumi_i = y & (sb.size() != 0);
      clr_i  = c;
      data_i = d;
      if (c) begin
         sum = model_drop + sb.size();
         model_drop = (sum > 65535) ? 65535 : sum;
         sb.delete();
      end else if (v && sb.size() != N) begin
         sb.push_back(d);
      end
   endtask

   // Monitor: every accepted dequeue must present the oldest expected message.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset_n && yumi_i) begin
            if (!v_o) begin
               checks++; failures++;
               $display("FAIL illegal_yumi: got v_o=0 expected v_o=1");
            end else if (!clr_i) begin
               if (sb.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL sb_empty: got dequeue expected none");
               end else begin
                  chk("data_o", data_o, sb.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; v_i = 0; yumi_i = 0; clr_i = 0; data_i = '0;
      #2;
      chk("rst_v_o", W'(v_o), W'(0));
      chk("rst_ready_o", W'(ready_o), W'(1));
      chk("rst_count_o", W'(count_o), W'(0));
      chk("rst_drop", W'(drop_count_o), W'(0));
      #10 reset_n = 1'b1;

      // Fill/drain with 0x1..0x8, then a 9th ignored enqueue.
      for (int i = 1; i <= 8; i++) step(1, 0, 0, W'(i));
      step(1, 0, 0, W'(9));
      step(0, 0, 0, '0);
      chk("full_count", W'(count_o), W'(8));
      chk("full_ready", W'(ready_o), W'(0));
      for (int i = 0; i < 8; i++) step(0, 1, 0, '0);
      step(0, 0, 0, '0);
      chk("drained_v", W'(v_o), W'(0));
      chk("drained_ready", W'(ready_o), W'(1));

      // Streaming at count 3 across pointer wrap.
      for (int i = 0; i < 3; i++) step(1, 0, 0, rnd_data());
      for (int i = 0; i < 40; i++) step(1, 1, 0, rnd_data());
      step(0, 0, 0, '0);
      chk("stream_count", W'(count_o), W'(3));

      // Full with simultaneous yumi: input refused.
      for (int i = 0; i < 5; i++) step(1, 0, 0, rnd_data());
      step(1, 1, 0, {W{1'b1}});
      step(0, 0, 0, '0);
      chk("full_yumi_count", W'(count_o), W'(7));
      for (int i = 0; i < 7; i++) step(0, 1, 0, '0);

      // Flush at count 5 with a concurrent enqueue and dequeue.
      for (int i = 0; i < 5; i++) step(1, 0, 0, rnd_data());
      step(1, 1, 1, rnd_data());
      step(0, 0, 0, '0);
      chk("flush_count", W'(count_o), W'(0));
      chk("flush_v", W'(v_o), W'(0));
      chk("flush_drop", W'(drop_count_o), W'(5));
      step(1, 0, 0, 128'hABCD_0123);
      step(0, 1, 0, '0);

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 31) == 0, rnd_data());
      step(0, 0, 1, '0);

      // Saturation: preload the drop counter near its ceiling.
      step(0, 0, 0, '0);
      force dut.drop_count_q = 16'hFFFE;
      #1 release dut.drop_count_q;
      model_drop = 16'hFFFE;
      for (int i = 0; i < 4; i++) step(1, 0, 0, rnd_data());
      step(0, 0, 1, '0);
      step(0, 0, 0, '0);
      chk("sat_drop", W'(drop_count_o), W'(16'hFFFF));
      for (int i = 0; i < 2; i++) step(1, 0, 0, rnd_data());
      step(0, 0, 1, '0);
      step(0, 0, 0, '0);
      chk("sat_hold", W'(drop_count_o), W'(16'hFFFF));

      // Asynchronous reset at count 6, between clock edges.
      for (int i = 0; i < 6; i++) step(1, 0, 0, rnd_data());
      @(posedge clk);
      #3;
      v_i = 0; yumi_i = 0; clr_i = 0;
      reset_n = 1'b0;
      #1;
      chk("arst_v_o", W'(v_o), W'(0));
      chk("arst_ready", W'(ready_o), W'(1));
      chk("arst_count", W'(count_o), W'(0));
      chk("arst_drop", W'(drop_count_o), W'(0));
      sb.delete();
      model_drop = 0;
      @(posedge clk);
      #2 reset_n = 1'b1;
      step(0, 0, 0, '0);
      chk("post_rst_v", W'(v_o), W'(0));
      chk("post_rst_ready", W'(ready_o), W'(1));
      chk("post_rst_drop", W'(drop_count_o), W'(0));
      step(1, 0, 0, 128'h55);
      step(0, 1, 0, '0);
      step(0, 0, 0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
